// File: rtl/rssb_ctrl.sv
// rssb_ctrl: fetch/read/exec sequencer for the RSSB (reverse subtract, skip if borrow) machine.
// Define RSSB_STEP_EN to add the step input and a PAUSE state after every instruction.
module rssb_ctrl #(
    parameter int WIDTH     = 8,
    parameter int RESET_PC  = 0,
    parameter int HALT_ADDR = 2**WIDTH - 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef RSSB_STEP_EN
    input  logic             step,
`endif
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] ram_addr,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_we,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] pc,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_READ  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
`ifdef RSSB_STEP_EN
        , S_PAUSE = 3'd5
`endif
    } state_t;

    localparam logic [WIDTH-1:0] PC_INIT = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] HALT_OP = WIDTH'(HALT_ADDR);

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_halted;
    logic             r_ram_we;

    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_resume;

    assign w_diff   = r_data - r_acc;
    assign w_borrow = (r_data < r_acc);

`ifdef RSSB_STEP_EN
    assign w_resume = step;
`else
    assign w_resume = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= PC_INIT;
            r_acc    <= '0;
            r_op     <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_ram_we <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state  <= S_FETCH;
                        r_pc     <= PC_INIT;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (rom_data == HALT_OP) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_op    <= rom_data;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_data   <= ram_rdata;
                    r_state  <= S_EXEC;
                    r_ram_we <= 1'b1;
                end
                S_EXEC: begin
                    r_acc <= w_diff;
                    r_pc  <= w_borrow ? r_pc + WIDTH'(2) : r_pc + WIDTH'(1);
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`ifdef RSSB_STEP_EN
                    r_state <= S_PAUSE;
`else
                    r_state <= S_FETCH;
`endif
                end
`ifdef RSSB_STEP_EN
                S_PAUSE: begin
                    if (w_resume) begin
                        r_state <= S_FETCH;
                    end
                end
`endif
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // w_resume is only consumed when the step feature is built in
    logic w_unused;
    assign w_unused = w_resume;

    assign rom_addr  = r_pc;
    assign ram_addr  = r_op;
    assign ram_wdata = w_diff;
    assign ram_we    = r_ram_we;
    assign acc       = r_acc;
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign instr_cnt = r_cnt;

endmodule

// File: doc/rssb_ctrl.md
Name: rssb_ctrl

Overview:
- Sequencer for the single-instruction RSSB (reverse subtract, skip if borrow) machine.
- Each program word in the 8-bit combinational program ROM is one operand address. The controller runs each instruction in a fixed three-cycle sequence:
  - fetch the operand from ROM;
  - read the data RAM at that address;
  - compute mem - acc, write it back and update the accumulator;
  - advance the program counter by 1, or by 2 on borrow.
- Sits between the program ROM, an external data RAM and the top-level run control.

Parameters:
- WIDTH, 8: data, address, pc and acc width.
- RESET_PC, 0: pc loaded on reset and on start.
- HALT_ADDR, 2**WIDTH-1: operand value that halts execution.
- CNT_W, 16: instruction counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution; sampled in IDLE/HALT only
- rom_addr  out  WIDTH  program ROM address (= pc)
- rom_data  in  WIDTH  combinational ROM output (operand address)
- ram_addr  out  WIDTH  data RAM address (= latched operand)
- ram_rdata  in  WIDTH  combinational RAM read data
- ram_wdata  out  WIDTH  write-back value
- ram_we  out  1  RAM write enable; RAM writes on the clk edge
- acc  out  WIDTH  accumulator
- pc  out  WIDTH  program counter
- busy  out  1  high in FETCH/READ/EXEC
- halted  out  1  high in HALT
- instr_cnt  out  CNT_W  retired instructions
- step  in  1  present only with RSSB_STEP_EN

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, acc=0, op_reg=0, data_reg=0, instr_cnt=0;
  - busy=0, halted=0, ram_we=0.
- Outputs:
  - rom_addr=pc, ram_addr=op_reg, ram_wdata=data_reg-acc (mod 2^WIDTH);
  - ram_we=1 only in EXEC; busy/halted decoded from state.
- IDLE: start=1 -> FETCH; pc=RESET_PC, acc=0, instr_cnt=0.
- FETCH:
  - rom_data==HALT_ADDR -> HALT; pc and acc unchanged, no RAM write.
  - Otherwise op_reg<=rom_data -> READ.
- READ: data_reg<=ram_rdata -> EXEC.
- EXEC:
  - ram_we=1 writes diff=data_reg-acc to op_reg; acc<=diff.
  - borrow = data_reg < acc (unsigned).
  - pc<=pc+2 if borrow, else pc+1; wraps modulo 2^WIDTH.
  - instr_cnt saturates at all-ones.
  - Next state: FETCH.
- HALT: holds all state. start=1 -> FETCH with the same reinitialisation as from IDLE.
- Timing:
  - Exactly 3 cycles per instruction.
  - First ROM fetch occurs in the cycle after start is sampled.
- Boundary conditions:
  - start while busy is ignored.
  - Operand equal to the pc address is legal; the RAM and ROM are separate.
  - data_reg==acc gives diff=0, no borrow.
  - Borrow at pc=2^WIDTH-1 gives pc=1.
  - rst mid-EXEC aborts the write; ram_we drops asynchronously.

Optional Feature:
- Macro: RSSB_STEP_EN.
- Defined:
  - Port step exists.
  - EXEC goes to state PAUSE instead of FETCH; busy=1 in PAUSE, ram_we=0.
  - PAUSE -> FETCH on a cycle with step=1; step is level-sampled, one instruction per sampled high cycle.
  - In PAUSE, a HALT_ADDR check is not made until FETCH.
- Undefined:
  - No step port, no PAUSE state.
  - EXEC -> FETCH always.

Test Plan:
- Reset and start:
  - Stimulus: assert rst mid-run.
  - Required: all outputs 0 immediately, state IDLE.
  - Stimulus: pulse start.
  - Required: rom_addr=0 next cycle, busy=1.
- No-borrow instruction:
  - Setup: ROM[0]=5, RAM[5]=2, acc=0.
  - Required, after 3 cycles: RAM[5]=2, acc=2, pc=1, instr_cnt=1.
- Borrow and skip:
  - Setup: ROM[1]=3, RAM[3]=1, acc=2.
  - Required: RAM[3]=0xFF, acc=0xFF, pc=3.
- Halt:
  - Setup: ROM[3]=0xFF.
  - Required: halted=1, busy=0, pc=3; no ram_we pulse.
  - Stimulus: start.
  - Required: restart at pc=0, acc=0, instr_cnt=0.
- PC wrap:
  - Setup: pc=0xFF with a borrowing operand.
  - Required: pc=0x01.
  - Setup: pc=0xFF without borrow.
  - Required: pc=0x00.
- Single-step (RSSB_STEP_EN):
  - Setup: step held 0.
  - Required: after one instruction, state PAUSE with busy=1 and pc frozen for 10 cycles.
  - Stimulus: one-cycle step.
  - Required: exactly one further instruction retires.
